ahb_mem_slave_p: RTL and testbench
==================================

// Module: ahb_mem_slave_p
// PURPOSE
//  Parametrised AHB slave with a byte-addressed on-chip memory.
//  - Successor to the fixed 32-bit memory slave.
//  - Adds: configurable data width, depth and wait states; true byte-lane write strobes;
//    two-cycle ERROR response; write-to-read forwarding.
//  - Sits behind the AHB decoder; one instance per HSELx.
// PARAMETERS
//  DATA_W      32    data bus width, 32 or 64
//  ADDR_W      32    HADDR width
//  MEM_BYTES   1024  memory size in bytes, power of 2, >= DATA_W/8
//  WAIT_STATES 0     wait cycles inserted in every OKAY data phase, 0..7
// PORTS
//  HCLK       in   1       clock
//  HRESETn    in   1       reset
//  HSELx      in   1       slave select from decoder
//  HADDR      in   ADDR_W  address (address phase)
//  HTRANS     in   2       IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HWRITE     in   1       1=write
//  HSIZE      in   3       bytes = 2**HSIZE
//  HBURST     in   3       burst type; informational only, master supplies every beat address
//  HWDATA     in   DATA_W  write data (data phase)
//  HREADY     in   1       bus-level ready (all slaves)
//  HREADYOUT  out  1       this slave's ready
//  HRESP      out  2       OKAY=00 ERROR=01 (RETRY/SPLIT never issued)
//  HRDATA     out  DATA_W  read data
// BEHAVIOUR
//  Reset:
//  - HRESETn is asynchronous, active-low; clock is HCLK.
//  - During reset: HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=IDLE, wait counter=0.
//  - Memory contents are not reset.
//  Address phase:
//  - Accepted on a rising edge when HSELx & HREADY & HTRANS[1].
//  - Latched: HADDR, HWRITE, HSIZE.
//  - IDLE/BUSY or unselected beats give a zero-wait OKAY data phase.
//  Error check (at accept):
//  - ERROR if HADDR >= MEM_BYTES, or 2**HSIZE > DATA_W/8, or HADDR is not aligned to 2**HSIZE.
//  - Errored writes never modify memory; errored reads return HRDATA=0.
//  FSM states: IDLE, WAIT, ERR1, ERR2.
//  - IDLE: accepted OK beat with WAIT_STATES>0 -> WAIT (HREADYOUT=0, cnt=WAIT_STATES-1).
//    Accepted OK beat with WAIT_STATES=0 -> stay IDLE (HREADYOUT=1). Error beat -> ERR1.
//  - WAIT: HREADYOUT=0, HRESP=OKAY. At cnt==0 the next cycle is final (HREADYOUT=1);
//    a new beat may be accepted there.
//  - ERR1: HREADYOUT=0, HRESP=ERROR -> ERR2.
//  - ERR2: HREADYOUT=1, HRESP=ERROR -> IDLE. An address accepted in ERR2 is processed normally.
//  Data path:
//  - Byte lanes are little-endian; lane = HADDR[log2(DATA_W/8)-1:0] .. +2**HSIZE-1.
//  - Write: only active lanes of HWDATA are stored, at the edge ending the final data-phase cycle.
//  - Read: HRDATA is valid in the final data-phase cycle (HREADYOUT=1). Inactive lanes = 0.
//  - Latency is WAIT_STATES+1 cycles from address accept to completion.
//  - Forwarding: a read accepted on the same edge a write commits to overlapping bytes returns
//    the new bytes.
//  Masking:
//  - HTRANS/HADDR are ignored while HREADY=0, i.e. the address is held by the master.
//  - Address bits above log2(MEM_BYTES) only feed the range check.
//  Reset mid-transfer:
//  - Outputs return to reset values; the pending write is dropped.
// TESTING
//  - Single word write 0xDEADBEEF @0x10, then read @0x10, WAIT_STATES=0 -> HRDATA=0xDEADBEEF,
//    no HREADYOUT low.
//  - Byte write 0xAA @0x13 over 0x11223344 word, HSIZE=0 -> read @0x10 gives 0xAA223344.
//  - INCR4 write 0..3 at 0x20 then WRAP4 read starting 0x28, WAIT_STATES=2 -> data 2,3,0,1;
//    each beat shows 2 cycles HREADYOUT=0.
//  - Read @MEM_BYTES -> HREADYOUT 0 then 1 with HRESP=ERROR both cycles; HRDATA=0.
//  - Misaligned halfword write @0x01 -> ERROR, and memory @0x00 is unchanged.
//  - Write 0x55 @0x40 immediately followed by read @0x40 -> 0x55 (forwarding);
//    assert HRESETn during a WAIT -> HREADYOUT=1, HRESP=OKAY asynchronously.

Source files
------------

// File: rtl/ahb_mem_slave_p_if.sv
// ahb_mem_slave_p_if
//   AHB bus bundle for one slave select of ahb_mem_slave_p.
//   Widths follow DATA_W / ADDR_W; the instance must match the slave parameters.
//   master modport : drives HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY
//                    (HREADY is the interconnect's bus-level ready, presented from the
//                    master side), observes HREADYOUT, HRESP, HRDATA
//   slave modport  : mirror image of master
interface ahb_mem_slave_p_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              HSELx;
   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [DATA_W-1:0] HWDATA;
   logic              HREADY;
   logic              HREADYOUT;
   logic [1:0]        HRESP;
   logic [DATA_W-1:0] HRDATA;

   modport master (
      output HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_mem_slave_p.sv
// ahb_mem_slave_p
//   AHB slave fronting a byte-addressed on-chip memory with little-endian byte lanes,
//   programmable wait states, a two-cycle ERROR response and write-to-read forwarding.
//   Ports:
//     HCLK     in  clock
//     HRESETn  in  asynchronous active-low reset
//     bus      ahb_mem_slave_p_if.slave : HSELx/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA/HREADY in,
//              HREADYOUT/HRESP/HRDATA out
//
//   state  | meaning
//   IDLE   | no stall; final cycle of an OKAY beat (if one is pending), may accept
//   WAIT   | OKAY beat stalled, HREADYOUT=0, counting wait cycles down
//   ERR1   | first ERROR cycle, HREADYOUT=0
//   ERR2   | second ERROR cycle, HREADYOUT=1, may accept
module ahb_mem_slave_p #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int MEM_BYTES   = 1024,
   parameter int WAIT_STATES = 0
) (
   input logic              HCLK,
   input logic              HRESETn,
   ahb_mem_slave_p_if.slave bus
);
   localparam int NB     = DATA_W / 8;
   localparam int LANE_W = $clog2(NB);
   localparam int MEM_AW = $clog2(MEM_BYTES);
   localparam int WORDS  = MEM_BYTES / NB;
   localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic              wr_q, wr_d;
   logic              err_q, err_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [2:0]        size_q, size_d;

   logic [DATA_W-1:0] mem_q [WORDS];

   logic              ready_out;
   logic              accept;
   logic              range_err, size_err, align_err, beat_err;
   logic [ADDR_W-1:0] align_mask;
   logic [NB-1:0]     lane_en;
   logic [WIDX_W-1:0] widx;
   logic              commit;
   logic [DATA_W-1:0] rdata;
   logic              unused_bits;

   // HBURST is informational and HTRANS[0] only separates NONSEQ from SEQ.
   assign unused_bits = ^{bus.HBURST, bus.HTRANS[0]};

   assign ready_out = (state_q == S_IDLE) || (state_q == S_ERR2);

   // A master cannot legally raise HREADY while this slave stalls, so only
   // ready cycles can carry an address phase for us.
   assign accept = bus.HSELx & bus.HREADY & bus.HTRANS[1] & ready_out;

   assign range_err  = |(bus.HADDR >> MEM_AW);
   assign size_err   = int'(bus.HSIZE) > LANE_W;
   assign align_mask = (ADDR_W'(1) << bus.HSIZE) - ADDR_W'(1);
   assign align_err  = |(bus.HADDR & align_mask);
   assign beat_err   = range_err | size_err | align_err;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         pend_q  <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         size_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      wr_d    = wr_q;
      err_d   = err_q;
      addr_d  = addr_q;
      size_d  = size_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q == 3'd0) state_d = S_IDLE;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_ERR1: state_d = S_ERR2;
         default: begin
            // IDLE / ERR2: any pending beat finishes this cycle
            state_d = S_IDLE;
            pend_d  = accept;
            if (accept) begin
               wr_d   = bus.HWRITE;
               err_d  = beat_err;
               addr_d = bus.HADDR[MEM_AW-1:0];
               size_d = bus.HSIZE;
               if (beat_err) begin
                  state_d = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
      endcase
   end

   always_comb begin
      lane_en = '0;
      for (int i = 0; i < NB; i++) begin
         if ((i >= int'(addr_q[LANE_W-1:0])) &&
             (i <  int'(addr_q[LANE_W-1:0]) + (1 << size_q)))
            lane_en[i] = 1'b1;
      end
   end

   assign widx   = WIDX_W'(addr_q >> LANE_W);
   assign commit = pend_q & wr_q & ~err_q & ready_out;

   // Writes land at the edge closing the final data cycle; a read accepted on
   // that same edge reads the array afterwards and so sees the new bytes.
   always_ff @(posedge HCLK) begin
      if (commit) begin
         for (int i = 0; i < NB; i++) begin
            if (lane_en[i]) mem_q[widx][i*8 +: 8] <= bus.HWDATA[i*8 +: 8];
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (pend_q & ~wr_q & ~err_q & ready_out) begin
         for (int i = 0; i < NB; i++) begin
            if (lane_en[i]) rdata[i*8 +: 8] = mem_q[widx][i*8 +: 8];
         end
      end
   end

   assign bus.HREADYOUT = ready_out;
   assign bus.HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
   assign bus.HRDATA    = rdata;

endmodule

// File: tb/tb_ahb_mem_slave_p.sv
module tb_ahb_mem_slave_p;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MB = 1024;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   ahb_mem_slave_p_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
   ahb_mem_slave_p_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

   ahb_mem_slave_p #(.DATA_W(DW), .ADDR_W(AW), .MEM_BYTES(MB), .WAIT_STATES(0)) dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0));
   ahb_mem_slave_p #(.DATA_W(DW), .ADDR_W(AW), .MEM_BYTES(MB), .WAIT_STATES(2)) dut1 (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1));

   logic        m_sel   [2];
   logic [31:0] m_addr  [2];
   logic [1:0]  m_trans [2];
   logic        m_write [2];
   logic [2:0]  m_size  [2];
   logic [2:0]  m_burst [2];
   logic [31:0] m_wdata [2];
   logic        s_ready [2];
   logic [1:0]  s_resp  [2];
   logic [31:0] s_rdata [2];

   assign bus0.HSELx  = m_sel[0];
   assign bus0.HADDR  = m_addr[0];
   assign bus0.HTRANS = m_trans[0];
   assign bus0.HWRITE = m_write[0];
   assign bus0.HSIZE  = m_size[0];
   assign bus0.HBURST = m_burst[0];
   assign bus0.HWDATA = m_wdata[0];
   assign bus0.HREADY = bus0.HREADYOUT;
   assign s_ready[0]  = bus0.HREADYOUT;
   assign s_resp[0]   = bus0.HRESP;
   assign s_rdata[0]  = bus0.HRDATA;

   assign bus1.HSELx  = m_sel[1];
   assign bus1.HADDR  = m_addr[1];
   assign bus1.HTRANS = m_trans[1];
   assign bus1.HWRITE = m_write[1];
   assign bus1.HSIZE  = m_size[1];
   assign bus1.HBURST = m_burst[1];
   assign bus1.HWDATA = m_wdata[1];
   assign bus1.HREADY = bus1.HREADYOUT;
   assign s_ready[1]  = bus1.HREADYOUT;
   assign s_resp[1]   = bus1.HRESP;
   assign s_rdata[1]  = bus1.HRDATA;

   // beat list, observations and model expectations
   logic        bq_wr   [16];
   logic [31:0] bq_addr [16];
   logic [2:0]  bq_size [16];
   logic [31:0] bq_data [16];
   logic [31:0] ob_rdata[16];
   logic [1:0]  ob_resp0[16];
   logic [1:0]  ob_resp1[16];
   int          ob_low  [16];
   int          ob_cyc  [16];
   logic [31:0] ex_rdata[16];
   logic        ex_err  [16];
   int          ex_low  [16];
   logic [7:0]  mem_m [2][MB];

   int n_tests = 0;
   int n_fail  = 0;

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   task automatic set_beat(input int k, input logic wr, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] dt);
      bq_wr[k] = wr; bq_addr[k] = a; bq_size[k] = s; bq_data[k] = dt;
   endtask

   // Reference model: beats complete strictly in order, so applying them one
   // after another to a byte array yields forwarding for free.
   task automatic model_exp(input int d, input int n);
      for (int k = 0; k < n; k++) begin
         int   nbytes;
         logic err;
         nbytes = 1 << bq_size[k];
         err = (bq_addr[k] >= MB) || (nbytes > DW/8) || ((bq_addr[k] % nbytes) != 0);
         ex_err[k]   = err;
         ex_low[k]   = err ? 1 : ws_of(d);
         ex_rdata[k] = '0;
         if (!err) begin
            for (int b = 0; b < nbytes; b++) begin
               int a, lane;
               a    = int'(bq_addr[k]) + b;
               lane = a % (DW/8);
               if (bq_wr[k]) mem_m[d][a] = bq_data[k][lane*8 +: 8];
               else          ex_rdata[k][lane*8 +: 8] = mem_m[d][a];
            end
         end
      end
   endtask

   // Pipelined master: address of beat k+1 overlaps the data phase of beat k.
   task automatic run_beats(input int d, input int n, input logic [2:0] burst);
      int   ai, di, cyc;
      logic rdy;
      ai = 0; di = -1; cyc = 0;
      for (int k = 0; k < n; k++) begin
         ob_low[k] = 0; ob_cyc[k] = 0; ob_resp0[k] = 2'b00; ob_resp1[k] = 2'b00; ob_rdata[k] = '0;
      end
      m_burst[d] = burst;
      while ((ai < n || di >= 0) && cyc < 200) begin
         if (ai < n) begin
            m_sel[d]   = 1'b1;
            m_trans[d] = (burst != 3'b000 && ai > 0) ? 2'b11 : 2'b10;
            m_addr[d]  = bq_addr[ai];
            m_write[d] = bq_wr[ai];
            m_size[d]  = bq_size[ai];
         end else begin
            m_sel[d]   = 1'b0;
            m_trans[d] = 2'b00;
         end
         if (di >= 0) m_wdata[d] = bq_wr[di] ? bq_data[di] : $urandom;
         @(negedge HCLK);
         rdy = s_ready[d];
         if (di >= 0) begin
            if (ob_cyc[di] == 0) ob_resp0[di] = s_resp[d];
            ob_cyc[di]++;
            if (!rdy) ob_low[di]++;
            else begin
               ob_resp1[di] = s_resp[d];
               ob_rdata[di] = s_rdata[d];
            end
         end
         @(posedge HCLK); #1;
         cyc++;
         if (rdy) begin
            if (ai < n) begin di = ai; ai++; end
            else di = -1;
         end
      end
      m_sel[d] = 1'b0; m_trans[d] = 2'b00;
      n_tests++;
      if (cyc >= 200) begin
         n_fail++;
         $display("FAIL run_timeout dut%0d cycles=%0d required<200", d, cyc);
      end
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (s_ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout dut%0d got %b exp 1", d, s_ready[d]); end
         n_tests++;
         if (s_resp[d] !== 2'b00) begin n_fail++; $display("FAIL reset_hresp dut%0d got %b exp 00", d, s_resp[d]); end
         n_tests++;
         if (s_rdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata dut%0d got %h exp 0", d, s_rdata[d]); end
      end
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
   endtask

   task automatic fill_mem();
      for (int d = 0; d < 2; d++) begin
         for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 16; k++) set_beat(k, 1'b1, 32'(blk*64 + k*4), 3'd2, $urandom);
            model_exp(d, 16);
            run_beats(d, 16, 3'b000);
         end
      end
   endtask

   task automatic test_single_word();
      set_beat(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
      set_beat(1, 1'b0, 32'h10, 3'd2, 32'h0);
      model_exp(0, 2);
      run_beats(0, 2, 3'b000);
      n_tests++;
      if (ob_rdata[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata got %h exp deadbeef", ob_rdata[1]); end
      n_tests++;
      if (ob_low[0] + ob_low[1] != 0) begin n_fail++; $display("FAIL single_nowait got %0d low cycles exp 0", ob_low[0] + ob_low[1]); end
      n_tests++;
      if (ob_resp1[1] !== 2'b00) begin n_fail++; $display("FAIL single_resp got %b exp 00", ob_resp1[1]); end
   endtask

   task automatic test_byte_write();
      set_beat(0, 1'b1, 32'h10, 3'd2, 32'h11223344);
      set_beat(1, 1'b1, 32'h13, 3'd0, 32'hAA000000);
      set_beat(2, 1'b0, 32'h10, 3'd2, 32'h0);
      set_beat(3, 1'b0, 32'h12, 3'd0, 32'h0);
      model_exp(0, 4);
      run_beats(0, 4, 3'b000);
      n_tests++;
      if (ob_rdata[2] !== 32'hAA223344) begin n_fail++; $display("FAIL byte_merge got %h exp aa223344", ob_rdata[2]); end
      n_tests++;
      if (ob_rdata[3] !== 32'h00220000) begin n_fail++; $display("FAIL byte_lane_read got %h exp 00220000", ob_rdata[3]); end
   endtask

   task automatic test_burst();
      int exp_b [4];
      exp_b = '{2, 3, 0, 1};
      for (int k = 0; k < 4; k++) set_beat(k, 1'b1, 32'(32'h20 + k*4), 3'd2, 32'(k));
      model_exp(1, 4);
      run_beats(1, 4, 3'b011);
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (ob_low[k] != 2) begin n_fail++; $display("FAIL burst_wr_wait beat%0d got %0d exp 2", k, ob_low[k]); end
      end
      set_beat(0, 1'b0, 32'h28, 3'd2, 32'h0);
      set_beat(1, 1'b0, 32'h2C, 3'd2, 32'h0);
      set_beat(2, 1'b0, 32'h20, 3'd2, 32'h0);
      set_beat(3, 1'b0, 32'h24, 3'd2, 32'h0);
      model_exp(1, 4);
      run_beats(1, 4, 3'b010);
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (ob_rdata[k] !== 32'(exp_b[k])) begin n_fail++; $display("FAIL burst_rdata beat%0d got %h exp %h", k, ob_rdata[k], exp_b[k]); end
         n_tests++;
         if (ob_low[k] != 2) begin n_fail++; $display("FAIL burst_rd_wait beat%0d got %0d exp 2", k, ob_low[k]); end
      end
   endtask

   task automatic test_error();
      set_beat(0, 1'b0, 32'(MB),       3'd2, 32'h0);
      set_beat(1, 1'b1, 32'h01,        3'd1, 32'hFFFFFFFF);
      set_beat(2, 1'b0, 32'h00,        3'd2, 32'h0);
      set_beat(3, 1'b0, 32'h08,        3'd3, 32'h0);
      set_beat(4, 1'b0, 32'h80000010,  3'd2, 32'h0);
      set_beat(5, 1'b0, 32'h10,        3'd2, 32'h0);
      model_exp(1, 6);
      run_beats(1, 6, 3'b000);
      n_tests++;
      if (ob_resp0[0] !== 2'b01 || ob_resp1[0] !== 2'b01) begin n_fail++; $display("FAIL err_range_resp got %b/%b exp 01/01", ob_resp0[0], ob_resp1[0]); end
      n_tests++;
      if (ob_low[0] != 1) begin n_fail++; $display("FAIL err_range_low got %0d exp 1", ob_low[0]); end
      n_tests++;
      if (ob_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL err_range_rdata got %h exp 0", ob_rdata[0]); end
      n_tests++;
      if (ob_resp1[1] !== 2'b01) begin n_fail++; $display("FAIL err_misalign_resp got %b exp 01", ob_resp1[1]); end
      n_tests++;
      if (ob_rdata[2] !== ex_rdata[2]) begin n_fail++; $display("FAIL err_mem_unchanged got %h exp %h", ob_rdata[2], ex_rdata[2]); end
      n_tests++;
      if (ob_resp1[3] !== 2'b01) begin n_fail++; $display("FAIL err_size_resp got %b exp 01", ob_resp1[3]); end
      n_tests++;
      if (ob_resp1[4] !== 2'b01) begin n_fail++; $display("FAIL err_highaddr_resp got %b exp 01", ob_resp1[4]); end
      n_tests++;
      if (ob_rdata[5] !== ex_rdata[5] || ob_resp1[5] !== 2'b00 || ob_low[5] != 2) begin
         n_fail++;
         $display("FAIL err_recover got %h/%b/%0d exp %h/00/2", ob_rdata[5], ob_resp1[5], ob_low[5], ex_rdata[5]);
      end
   endtask

   task automatic test_back_to_back();
      for (int d = 0; d < 2; d++) begin
         set_beat(0, 1'b1, 32'h40, 3'd0, 32'h00000055);
         set_beat(1, 1'b0, 32'h40, 3'd0, 32'h0);
         set_beat(2, 1'b0, 32'h40, 3'd2, 32'h0);
         model_exp(d, 3);
         run_beats(d, 3, 3'b000);
         n_tests++;
         if (ob_rdata[1] !== 32'h00000055) begin n_fail++; $display("FAIL fwd_byte dut%0d got %h exp 00000055", d, ob_rdata[1]); end
         n_tests++;
         if (ob_rdata[2] !== ex_rdata[2]) begin n_fail++; $display("FAIL fwd_word dut%0d got %h exp %h", d, ob_rdata[2], ex_rdata[2]); end
      end
   endtask

   task automatic test_random();
      for (int d = 0; d < 2; d++) begin
         for (int batch = 0; batch < 3; batch++) begin
            for (int k = 0; k < 16; k++) begin
               int          r, nb;
               logic [2:0]  s;
               logic [31:0] a;
               r = int'($urandom % 16);
               s = (r < 5) ? 3'd0 : (r < 10) ? 3'd1 : (r < 15) ? 3'd2 : 3'd3;
               nb = 1 << s;
               a = 32'(($urandom % 256) & ~(nb - 1));
               r = int'($urandom % 16);
               if (r == 0) a = a | 32'h1;
               else if (r == 1) a = a + 32'(MB);
               else if (r == 2) a = 32'hFFFFFF00;
               set_beat(k, 1'($urandom % 2), a, s, $urandom);
            end
            model_exp(d, 16);
            run_beats(d, 16, 3'b000);
            for (int k = 0; k < 16; k++) begin
               n_tests++;
               if (ob_resp1[k] !== (ex_err[k] ? 2'b01 : 2'b00) || ob_resp0[k] !== (ex_err[k] ? 2'b01 : 2'b00)) begin
                  n_fail++;
                  $display("FAIL rand_resp dut%0d beat%0d addr %h got %b/%b exp err=%b", d, k, bq_addr[k], ob_resp0[k], ob_resp1[k], ex_err[k]);
               end
               n_tests++;
               if (ob_low[k] != ex_low[k]) begin n_fail++; $display("FAIL rand_wait dut%0d beat%0d got %0d exp %0d", d, k, ob_low[k], ex_low[k]); end
               if (!bq_wr[k]) begin
                  n_tests++;
                  if (ob_rdata[k] !== ex_rdata[k]) begin
                     n_fail++;
                     $display("FAIL rand_rdata dut%0d beat%0d addr %h size %0d got %h exp %h", d, k, bq_addr[k], bq_size[k], ob_rdata[k], ex_rdata[k]);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      m_sel[1] = 1'b1; m_trans[1] = 2'b10; m_addr[1] = 32'h80; m_write[1] = 1'b1; m_size[1] = 3'd2;
      @(posedge HCLK); #1;
      m_sel[1] = 1'b0; m_trans[1] = 2'b00; m_wdata[1] = 32'h12345678;
      @(negedge HCLK);
      n_tests++;
      if (s_ready[1] !== 1'b0) begin n_fail++; $display("FAIL midrst_in_wait got %b exp 0", s_ready[1]); end
      #2 HRESETn = 1'b0;
      #1;
      n_tests++;
      if (s_ready[1] !== 1'b1) begin n_fail++; $display("FAIL midrst_hreadyout got %b exp 1", s_ready[1]); end
      n_tests++;
      if (s_resp[1] !== 2'b00) begin n_fail++; $display("FAIL midrst_hresp got %b exp 00", s_resp[1]); end
      n_tests++;
      if (s_rdata[1] !== 32'h0) begin n_fail++; $display("FAIL midrst_hrdata got %h exp 0", s_rdata[1]); end
      @(posedge HCLK); @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      set_beat(0, 1'b0, 32'h80, 3'd2, 32'h0);
      model_exp(1, 1);
      run_beats(1, 1, 3'b000);
      n_tests++;
      if (ob_rdata[0] !== ex_rdata[0]) begin n_fail++; $display("FAIL midrst_write_dropped got %h exp %h", ob_rdata[0], ex_rdata[0]); end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_sel[d] = 1'b0; m_addr[d] = '0; m_trans[d] = 2'b00; m_write[d] = 1'b0;
         m_size[d] = 3'd0; m_burst[d] = 3'd0; m_wdata[d] = '0;
      end
      test_reset();
      fill_mem();
      test_single_word();
      test_byte_write();
      test_burst();
      test_error();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
